// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and refresh sequencer state type.
// Commands are encoded as {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

    typedef enum logic [3:0] {
        CmdLoadMode    = 4'b0000,
        CmdAutoRefresh = 4'b0001,
        CmdPrecharge   = 4'b0010,
        CmdActive      = 4'b0011,
        CmdWrite       = 4'b0100,
        CmdRead        = 4'b0101,
        CmdNop         = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StPrecharge,
        StWaitTrp,
        StRefresh,
        StWaitTrfc
    } refresh_state_e;

endpackage

// File: rtl/sdram_refresh_sequencer.sv
// Banks refresh requests from the refresh timer and issues PRECHARGE ALL + AUTO REFRESH
// sequences when the user path is idle, holding the user path while the bus is owned.
module sdram_refresh_sequencer
    import sdram_pkg::*;
#(
    parameter int unsigned TrpCycles  = 3,
    parameter int unsigned TrfcCycles = 9,
    parameter int unsigned MaxPending = 8
) (
    input  logic       i_dram_clk,
    input  logic       i_rst_n,
    input  logic       i_init_done,
    input  logic       i_refresh_req,
    output logic       o_refresh_ack,
    output logic       o_refresh_en,
    input  logic       i_user_idle,
    output logic       o_user_hold,
    output logic       o_refresh_active,
    output logic [3:0] o_cmd,
    output logic       o_a10
);

    localparam int unsigned PendW  = $clog2(MaxPending + 1);
    localparam int unsigned TmrMax = (TrpCycles > TrfcCycles) ? TrpCycles : TrfcCycles;
    localparam int unsigned TmrW   = $clog2(TmrMax);

    localparam logic [PendW-1:0] PendFull = PendW'(MaxPending);
    localparam logic [PendW-1:0] PendOne  = PendW'(1);
    localparam logic [TmrW-1:0]  TmrOne   = TmrW'(1);
    // Wait states last N-1 cycles; the counter runs from N-2 down to 0.
    localparam logic [TmrW-1:0]  TrpLoad  = TmrW'(TrpCycles - 2);
    localparam logic [TmrW-1:0]  TrfcLoad = TmrW'(TrfcCycles - 2);

    refresh_state_e   state_q, state_d;
    logic [PendW-1:0] pending_q, pending_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic             ack_q, ack_d;
    logic             en_q, en_d;
    logic             hold_q, hold_d;
    logic             active_q, active_d;
    logic             a10_q, a10_d;
    sdram_cmd_e       cmd_q, cmd_d;
    logic             refresh_issued;

    // cmd_q tracks state_q, so the AUTO REFRESH on the bus is exactly the REFRESH state.
    assign refresh_issued = (state_q == StRefresh);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        ack_d     = i_refresh_req & ~ack_q & (pending_q < PendFull) & i_init_done;
        en_d      = i_init_done;

        if (ack_q && !refresh_issued) begin
            pending_d = pending_q + PendOne;
        end else if (!ack_q && refresh_issued && (pending_q != '0)) begin
            pending_d = pending_q - PendOne;
        end

        // A full backlog only forces the hold; the sequence still waits for an idle user path.
        unique case (state_q)
            StIdle: begin
                if ((pending_q != '0) && i_user_idle) begin
                    state_d = StPrecharge;
                end
            end
            StPrecharge: begin
                state_d = StWaitTrp;
                timer_d = TrpLoad;
            end
            StWaitTrp: begin
                if (timer_q == '0) begin
                    state_d = StRefresh;
                end else begin
                    timer_d = timer_q - TmrOne;
                end
            end
            StRefresh: begin
                state_d = StWaitTrfc;
                timer_d = TrfcLoad;
            end
            StWaitTrfc: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TmrOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!i_init_done) begin
            state_d   = StIdle;
            timer_d   = '0;
            pending_d = '0;
            ack_d     = 1'b0;
        end

        active_d = (state_d != StIdle);
        hold_d   = active_d | ((pending_d == PendFull) & ~i_user_idle);
        a10_d    = (state_d == StPrecharge);
        if (state_d == StPrecharge) begin
            cmd_d = CmdPrecharge;
        end else if (state_d == StRefresh) begin
            cmd_d = CmdAutoRefresh;
        end else begin
            cmd_d = CmdNop;
        end
    end

    always_ff @(posedge i_dram_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            timer_q   <= '0;
            ack_q     <= 1'b0;
            en_q      <= 1'b0;
            hold_q    <= 1'b0;
            active_q  <= 1'b0;
            a10_q     <= 1'b0;
            cmd_q     <= CmdNop;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            en_q      <= en_d;
            hold_q    <= hold_d;
            active_q  <= active_d;
            a10_q     <= a10_d;
            cmd_q     <= cmd_d;
        end
    end

    assign o_refresh_ack    = ack_q;
    assign o_refresh_en     = en_q;
    assign o_user_hold      = hold_q;
    assign o_refresh_active = active_q;
    assign o_a10            = a10_q;
    assign o_cmd            = cmd_q;

endmodule

// File: tb/tb_sdram_refresh_sequencer.sv
// Self-checking bench for sdram_refresh_sequencer: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model based on sequence offsets.
module tb_sdram_refresh_sequencer;

    localparam int TRP  = 3;
    localparam int TRFC = 9;
    localparam int MAXP = 8;

    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdAr  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic       refresh_req;
    logic       refresh_ack;
    logic       refresh_en;
    logic       user_idle;
    logic       user_hold;
    logic       refresh_active;
    logic [3:0] cmd;
    logic       a10;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_left = 0;
    bit auto_req = 0;

    sdram_refresh_sequencer #(
        .TrpCycles (TRP),
        .TrfcCycles(TRFC),
        .MaxPending(MAXP)
    ) dut (
        .i_dram_clk      (clk),
        .i_rst_n         (rst_n),
        .i_init_done     (init_done),
        .i_refresh_req   (refresh_req),
        .o_refresh_ack   (refresh_ack),
        .o_refresh_en    (refresh_en),
        .i_user_idle     (user_idle),
        .o_user_hold     (user_hold),
        .o_refresh_active(refresh_active),
        .o_cmd           (cmd),
        .o_a10           (a10)
    );

    always #5 clk = ~clk;

    // Behavioural model: a sequence is an offset counter 0..TRP+TRFC-1 from its PRECHARGE.
    int         m_pending = 0;
    int         m_off     = -1;
    bit         m_ack, m_en, m_hold, m_active, m_a10;
    logic [3:0] m_cmd = CmdNop;

    always @(posedge clk) begin : model
        int np;
        int noff;
        bit nack;
        if (!rst_n) begin
            m_pending = 0; m_off = -1; m_ack = 0; m_en = 0;
            m_hold = 0; m_active = 0; m_a10 = 0; m_cmd = CmdNop;
        end else begin
            np = m_pending + (m_ack ? 1 : 0) - ((m_off == TRP && m_pending > 0) ? 1 : 0);
            nack = refresh_req && !m_ack && (m_pending < MAXP) && init_done;
            if (!init_done) begin
                np = 0; nack = 0; noff = -1;
            end else if (m_off >= 0 && m_off < TRP + TRFC - 1) begin
                noff = m_off + 1;
            end else if (m_off < 0 && m_pending > 0 && user_idle) begin
                noff = 0;
            end else begin
                noff = -1;
            end
            m_ack     = nack;
            m_en      = init_done;
            m_active  = (noff >= 0);
            m_a10     = (noff == 0);
            m_cmd     = (noff == 0) ? CmdPre : ((noff == TRP) ? CmdAr : CmdNop);
            m_hold    = m_active || (np == MAXP && !user_idle);
            m_pending = np;
            m_off     = noff;
        end
    end

    // Advance to the next sample point; the auto requester drops req for the cycle after an ack.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (auto_req) begin
            if (refresh_ack && req_left > 0) req_left--;
            refresh_req = (req_left > 0) && !refresh_ack;
        end
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            ok = (req_left == 0) && !refresh_req && (dut.pending_q == 0) && !refresh_active
                 && !refresh_ack;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; init_done = 0; user_idle = 1; refresh_req = 0;
        repeat (3) tick();
        checks++;
        if ({refresh_ack, refresh_en, user_hold, refresh_active, a10} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {refresh_ack, refresh_en, user_hold, refresh_active, a10});
        end
        checks++;
        if (cmd !== CmdNop) begin
            failures++;
            $display("FAIL reset_cmd: got %b expected %b", cmd, CmdNop);
        end
        checks++;
        if (dut.pending_q !== 0) begin
            failures++;
            $display("FAIL reset_pending: got %0d expected 0", dut.pending_q);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_idle_bus();
        int k_ack = -1, k_pre = -1, k_ar = -1, k_end = -1;
        bit a10_pre = 0;
        init_done = 1; user_idle = 1; auto_req = 1;
        tick();
        req_left = 1; refresh_req = 1;
        for (int k = 1; k <= 40 && k_end < 0; k++) begin
            tick();
            if (refresh_ack && k_ack < 0) k_ack = k;
            if (cmd === CmdPre && k_pre < 0) begin k_pre = k; a10_pre = a10; end
            if (cmd === CmdAr && k_ar < 0) k_ar = k;
            if (k_pre >= 0 && !refresh_active && k_end < 0) k_end = k;
        end
        checks++;
        if (k_ack !== 1) begin failures++; $display("FAIL idle_ack_cycle: got %0d expected 1", k_ack); end
        checks++;
        if (k_pre !== 3) begin failures++; $display("FAIL idle_pre_cycle: got %0d expected 3", k_pre); end
        checks++;
        if (a10_pre !== 1) begin failures++; $display("FAIL idle_pre_a10: got %0d expected 1", a10_pre); end
        checks++;
        if (k_ar !== 3 + TRP) begin
            failures++; $display("FAIL idle_ar_cycle: got %0d expected %0d", k_ar, 3 + TRP);
        end
        checks++;
        if (k_end !== 3 + TRP + TRFC) begin
            failures++; $display("FAIL idle_active_fall: got %0d expected %0d", k_end, 3 + TRP + TRFC);
        end
        checks++;
        if (dut.pending_q !== 0) begin
            failures++; $display("FAIL idle_pending: got %0d expected 0", dut.pending_q);
        end
    endtask

    task automatic test_busy_user();
        int acks = 0, busy_cmds = 0, ars = 0;
        bit ok = 0;
        user_idle = 0; auto_req = 1; req_left = 3;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (refresh_ack) acks++;
            if (cmd !== CmdNop) busy_cmds++;
        end
        checks++;
        if (acks !== 3) begin failures++; $display("FAIL busy_acks: got %0d expected 3", acks); end
        checks++;
        if (dut.pending_q !== 3) begin
            failures++; $display("FAIL busy_pending: got %0d expected 3", dut.pending_q);
        end
        checks++;
        if (busy_cmds !== 0) begin failures++; $display("FAIL busy_cmds: got %0d expected 0", busy_cmds); end
        checks++;
        if (user_hold !== 0) begin failures++; $display("FAIL busy_hold: got %0d expected 0", user_hold); end
        user_idle = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (cmd === CmdAr) ars++;
            ok = (dut.pending_q == 0) && !refresh_active;
        end
        checks++;
        if (ars !== 3 || !ok) begin
            failures++; $display("FAIL busy_drain: got %0d refreshes (done=%0d) expected 3", ars, ok);
        end
    endtask

    task automatic test_backlog_full();
        int acks = 0, ars = 0, ar_k = -1, ack_k = -1;
        bit ok = 0;
        user_idle = 0; auto_req = 1; req_left = MAXP + 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (refresh_ack) acks++;
        end
        checks++;
        if (acks !== MAXP) begin failures++; $display("FAIL full_acks: got %0d expected %0d", acks, MAXP); end
        checks++;
        if (dut.pending_q !== MAXP) begin
            failures++; $display("FAIL full_pending: got %0d expected %0d", dut.pending_q, MAXP);
        end
        checks++;
        if (user_hold !== 1) begin failures++; $display("FAIL full_hold: got %0d expected 1", user_hold); end
        user_idle = 1;
        for (int i = 1; i <= 400 && !ok; i++) begin
            tick();
            if (cmd === CmdAr) begin ars++; if (ar_k < 0) ar_k = i; end
            if (refresh_ack && ack_k < 0) ack_k = i;
            ok = (req_left == 0) && (dut.pending_q == 0) && !refresh_active;
        end
        // The count drops on the edge ending AUTO REFRESH; the registered ack follows one edge later.
        checks++;
        if (ack_k - ar_k !== 2) begin
            failures++; $display("FAIL full_late_ack: got delta %0d expected 2", ack_k - ar_k);
        end
        checks++;
        if (ars !== MAXP + 1 || !ok) begin
            failures++;
            $display("FAIL full_drain: got %0d refreshes (done=%0d) expected %0d", ars, ok, MAXP + 1);
        end
    endtask

    task automatic test_simultaneous();
        int acks = 0;
        bit ok;
        user_idle = 1; auto_req = 0; req_left = 0;
        refresh_req = 1;
        tick();
        refresh_req = 0;
        repeat (4) tick();
        refresh_req = 1;
        tick();
        checks++;
        if (cmd !== CmdAr || refresh_ack !== 1) begin
            failures++;
            $display("FAIL simul_coincide: got cmd=%b ack=%0d expected cmd=%b ack=1", cmd, refresh_ack, CmdAr);
        end
        if (refresh_ack) acks++;
        tick();
        if (refresh_ack) acks++;
        checks++;
        if (dut.pending_q !== 1) begin
            failures++; $display("FAIL simul_pending: got %0d expected 1", dut.pending_q);
        end
        refresh_req = 0;
        repeat (3) begin tick(); if (refresh_ack) acks++; end
        checks++;
        if (acks !== 1) begin failures++; $display("FAIL simul_single_ack: got %0d expected 1", acks); end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL simul_drain: got busy expected idle"); end
    endtask

    task automatic test_init_gating();
        int bad = 0;
        bit ok;
        auto_req = 0; user_idle = 1;
        init_done = 0; refresh_req = 1;
        repeat (6) begin
            tick();
            if (refresh_ack !== 0 || refresh_en !== 0 || cmd !== CmdNop) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL init_gated: got %0d bad cycles expected 0", bad); end
        init_done = 1;
        tick();
        checks++;
        if (refresh_en !== 1) begin failures++; $display("FAIL init_enable: got %0d expected 1", refresh_en); end
        refresh_req = 0;
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL init_drain: got busy expected idle"); end
    endtask

    task automatic test_reset_mid_trfc();
        bit seen_ar = 0;
        user_idle = 1; auto_req = 1; req_left = 1; refresh_req = 1;
        for (int i = 0; i < 30 && !seen_ar; i++) begin
            tick();
            seen_ar = (cmd === CmdAr);
        end
        checks++;
        if (!seen_ar) begin failures++; $display("FAIL rst_mid_reach: got no refresh expected one"); end
        repeat (2) tick();
        auto_req = 0; req_left = 0; refresh_req = 0;
        rst_n = 0;
        tick();
        checks++;
        if ({refresh_ack, refresh_en, user_hold, refresh_active, a10} !== 5'b0 || cmd !== CmdNop) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %b cmd=%b expected 00000 cmd=%b",
                     {refresh_ack, refresh_en, user_hold, refresh_active, a10}, cmd, CmdNop);
        end
        checks++;
        if (dut.pending_q !== 0) begin
            failures++; $display("FAIL rst_mid_pending: got %0d expected 0", dut.pending_q);
        end
        rst_n = 1;
        tick();
        test_idle_bus();
    endtask

    task automatic test_random();
        int  bad = 0, init_low = 0, busy_pct = 10;
        bit  ok;
        logic [8:0] obs, exp;
        auto_req = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) busy_pct = $urandom_range(0, 95);
            user_idle = ($urandom_range(0, 99) >= busy_pct);
            if ($urandom_range(0, 99) < 8 && req_left < 12) req_left++;
            if (init_low > 0) init_low--;
            else if ($urandom_range(0, 699) == 0) init_low = $urandom_range(2, 8);
            init_done = (init_low == 0);
            tick();
            obs = {refresh_ack, refresh_en, user_hold, refresh_active, a10, cmd};
            exp = {m_ack, m_en, m_hold, m_active, m_a10, m_cmd};
            checks++;
            if (obs !== exp || int'(dut.pending_q) !== m_pending) begin
                failures++;
                if (bad < 10)
                    $display("FAIL rand_cycle%0d: got outs=%b pend=%0d expected outs=%b pend=%0d",
                             i, obs, dut.pending_q, exp, m_pending);
                bad++;
            end
        end
        init_done = 1; user_idle = 1;
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rand_drain: got busy expected idle"); end
    endtask

    initial begin
        rst_n = 0; init_done = 0; user_idle = 1; refresh_req = 0;
        test_reset();
        test_idle_bus();
        test_busy_user();
        test_backlog_full();
        test_simultaneous();
        test_init_gating();
        test_reset_mid_trfc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
